// File: rtl/ram_dp_sync_param.sv
// Parametrised true dual-port synchronous RAM with a shared clock.
// Each port (A, B) can read and write independently. The block also provides:
//   - a selectable same-port read-during-write mode,
//   - an optional output register,
//   - write-write collision detection,
//   - a reset-driven sequencer that zeroes every word.
module ram_dp_sync_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int RD_MODE    = 0,   // 0: write-first, 1: read-first (same port)
  parameter int OUT_REG    = 0,   // 1: extra output stage, read latency 2
  parameter int INIT_CLEAR = 1    // 1: zero the whole array after reset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              init_busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              busy_reg, busy_next;
  logic              collision_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports are packed side by side, so the read path can be generated
  // once per port. Index 0 is port A and index 1 is port B.
  logic [1:0]             port_en;
  logic [1:0]             port_we;
  logic [1:0][ADDR_W-1:0] port_addr;
  logic [1:0][DATA_W-1:0] port_din;
  logic [1:0][DATA_W-1:0] port_dout;

  // Port accesses are accepted only while the RAM is idle. The RAM is not
  // idle while reset is asserted or while the clear sequence is running.
  logic access_ok;
  logic wr_a;
  logic wr_b;

  assign port_en   = {b_en, a_en};
  assign port_we   = {b_we, a_we};
  assign port_addr = {b_addr, a_addr};
  assign port_din  = {b_din, a_din};

  assign access_ok = !rst && !busy_reg;
  assign wr_a      = access_ok && a_en && a_we;
  assign wr_b      = access_ok && b_en && b_we;

  assign a_dout    = port_dout[0];
  assign b_dout    = port_dout[1];
  assign init_busy = busy_reg;
  assign collision = collision_reg;

  // Sequencer state: choose the start state and reload the clear counter on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  // Sequencer next state: walk every address once, then release the ports.
  // Busy drops on the same edge that clears the last word.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next  = cnt_reg + 1'b1;
        busy_next = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_RUN;
          busy_next  = 1'b0;
        end
      end
      default: begin
        busy_next = 1'b0;
      end
    endcase
  end

  // Array writes. The clear sequencer owns the array while it runs.
  // Port A's write is issued last, so on a same-address double write
  // port A's data is the one that is stored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == ST_CLEAR) begin
        mem[cnt_reg] <= '0;
      end else begin
        if (wr_b) begin
          mem[b_addr] <= b_din;
        end
        if (wr_a) begin
          mem[a_addr] <= a_din;
        end
      end
    end
  end

  // Flag a same-address double write for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_reg <= 1'b0;
    end else begin
      collision_reg <= wr_a && wr_b && (a_addr == b_addr);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_q_reg;

      // First read stage. It holds its value while the port is disabled.
      // Reading mem here returns the pre-edge contents. A cross-port read of
      // a word being written in the same cycle therefore sees the old data.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q_reg <= '0;
        end else if (access_ok && port_en[gi]) begin
          if ((RD_MODE == 0) && port_we[gi]) begin
            rd_q_reg <= port_din[gi];
          end else begin
            rd_q_reg <= mem[port_addr[gi]];
          end
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] out_q_reg;

        // Output stage advances every cycle, so data already in flight
        // still completes after the port is disabled.
        always_ff @(posedge clk) begin
          if (rst) begin
            out_q_reg <= '0;
          end else begin
            out_q_reg <= rd_q_reg;
          end
        end

        assign port_dout[gi] = out_q_reg;
      end else begin : g_no_out_reg
        assign port_dout[gi] = rd_q_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_sync_param.sv
// Testbench for ram_dp_sync_param, configured as 8x16 with write-first reads,
// an output register and clear-on-reset.
module tb_ram_dp_sync_param;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int RD_MODE    = 0;
  localparam int OUT_REG    = 1;
  localparam int INIT_CLEAR = 1;
  localparam int LAT        = 1 + OUT_REG;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_en = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_din = '0;
  logic [DATA_W-1:0] a_dout;
  logic              b_en = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_din = '0;
  logic [DATA_W-1:0] b_dout;
  logic              init_busy;
  logic              collision;

  ram_dp_sync_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG), .INIT_CLEAR(INIT_CLEAR)
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
    .init_busy(init_busy), .collision(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;   // 0 = A, 1 = B
    logic [7:0]  data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0;
    b_en = 1'b0; b_we = 1'b0;
  endtask

  // Record the value a read issued now must present, LAT edges later.
  task automatic expect_rd(input bit port, input logic [7:0] d, input string name);
    exp_t e;
    e.port = port; e.data = d; e.due = cyc + LAT; e.name = name;
    sb.push_back(e);
  endtask

  // Advance (bounded) to the due cycle of the oldest entry and pop it, returning
  // the observed output alongside the expected value.
  task automatic next_out(output logic [7:0] got, output logic [7:0] want,
                          output bit ok, output string name);
    int guard;
    guard = 0;
    ok = 1'b0; got = 'x; want = 'x; name = "empty_queue";
    if (sb.size() != 0) begin
      while (cyc < sb[0].due && guard < 10) begin
        step();
        guard++;
      end
      ok   = (cyc == sb[0].due);
      want = sb[0].data;
      name = sb[0].name;
      got  = sb[0].port ? b_dout : a_dout;
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    int busy_cnt;
    rst = 1'b1; idle();
    step(); step();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
    checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_dout: got %02h expected 00", a_dout); end
    checks++; if (b_dout !== 8'h00) begin errors++; $display("FAIL reset_b_dout: got %02h expected 00", b_dout); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
    rst = 1'b0;
    // Writes and a would-be collision during the clear must be ignored.
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_din = 8'hAA;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd3; b_din = 8'hBB;
    busy_cnt = 0;
    while (init_busy === 1'b1 && busy_cnt < 100) begin
      step();
      busy_cnt++;
      if (busy_cnt == 5) begin
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL clear_collision: got %b expected 0", collision); end
        checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL clear_a_dout: got %02h expected 00", a_dout); end
      end
    end
    idle();
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 16", busy_cnt); end
    $display("reset/clear: init_busy high for %0d cycles", busy_cnt);
  endtask

  task automatic test_clear_readback();
    logic [7:0] got, want; bit ok; string nm;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        a_en = 1'b1; a_addr = 4'(i);
        expect_rd(1'b0, 8'h00, $sformatf("clear_rd_a_%0d", i));
      end else begin
        b_en = 1'b1; b_addr = 4'(i);
        expect_rd(1'b1, 8'h00, $sformatf("clear_rd_b_%0d", i));
      end
      step(); idle();
      next_out(got, want, ok, nm);
      checks++;
      if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
      $display("readback addr %0d: %02h", i, got);
    end
  endtask

  task automatic test_latency();
    logic [7:0] got, want; bit ok; string nm;
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_din = 8'h5C;
    step(); idle();
    b_en = 1'b1; b_addr = 4'd7;
    expect_rd(1'b1, 8'h5C, "latency_b_rd7");
    step(); idle();
    next_out(got, want, ok, nm);
    checks++;
    if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    step(); step(); step();
    checks++;
    if (b_dout !== 8'h5C) begin errors++; $display("FAIL latency_hold: got %02h expected 5c", b_dout); end
    $display("latency: b_dout=%02h after read of addr 7", got);
  endtask

  task automatic test_rd_mode();
    logic [7:0] got, want; bit ok; string nm;
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_din = 8'h11;
    step(); idle();
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_din = 8'h22;
    expect_rd(1'b0, (RD_MODE == 0) ? 8'h22 : 8'h11, "rdw_same_port");
    step(); idle();
    next_out(got, want, ok, nm);
    checks++;
    if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    a_en = 1'b1; a_addr = 4'd2;
    expect_rd(1'b0, 8'h22, "rdw_followup");
    step(); idle();
    next_out(got, want, ok, nm);
    checks++;
    if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    $display("rd_mode: follow-up read addr 2 = %02h", got);
  endtask

  task automatic test_cross_port();
    logic [7:0] got, want; bit ok; string nm;
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_din = 8'h33;
    step(); idle();
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_din = 8'h44;
    b_en = 1'b1; b_addr = 4'd9;
    expect_rd(1'b0, (RD_MODE == 0) ? 8'h44 : 8'h33, "cross_a_rdw");
    expect_rd(1'b1, 8'h33, "cross_b_old");
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      next_out(got, want, ok, nm);
      checks++;
      if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    end
    b_en = 1'b1; b_addr = 4'd9;
    expect_rd(1'b1, 8'h44, "cross_b_new");
    step(); idle();
    next_out(got, want, ok, nm);
    checks++;
    if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    $display("cross_port: next B read of addr 9 = %02h", got);
  endtask

  task automatic test_collision();
    logic [7:0] got, want; bit ok; string nm;
    int c0;
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_din = 8'h0F;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_din = 8'hF0;
    expect_rd(1'b0, (RD_MODE == 0) ? 8'h0F : 8'h00, "coll_a_rdw");
    expect_rd(1'b1, (RD_MODE == 0) ? 8'hF0 : 8'h00, "coll_b_rdw");
    step(); idle();
    c0 = cyc;
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL coll_pulse: got %b expected 1", collision); end
    for (int k = 0; k < 2; k++) begin
      next_out(got, want, ok, nm);
      checks++;
      if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    end
    if (cyc == c0) step();
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL coll_one_cycle: got %b expected 0", collision); end
    a_en = 1'b1; a_addr = 4'd5;
    expect_rd(1'b0, 8'h0F, "coll_stored_a");
    step(); idle();
    next_out(got, want, ok, nm);
    checks++;
    if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    // Different addresses: both stored, no collision.
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_din = 8'h55;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd6; b_din = 8'h66;
    step(); idle();
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL coll_diff_addr: got %b expected 0", collision); end
    a_en = 1'b1; a_addr = 4'd5;
    b_en = 1'b1; b_addr = 4'd6;
    expect_rd(1'b0, 8'h55, "diff_addr_a5");
    expect_rd(1'b1, 8'h66, "diff_addr_b6");
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      next_out(got, want, ok, nm);
      checks++;
      if (!ok || got !== want) begin errors++; $display("FAIL %s: got %02h expected %02h ok=%0d", nm, got, want, ok); end
    end
    $display("collision: addr 5/6 writes stored, last read %02h", got);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a_list [5];
    logic [3:0] b_list [5];
    logic [7:0] a_exp  [5];
    logic [7:0] b_exp  [5];
    logic [7:0] got;
    a_list = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd2};
    a_exp  = '{8'h55, 8'h66, 8'h5C, 8'h44, 8'h22};
    b_list = '{4'd2, 4'd9, 4'd7, 4'd6, 4'd5};
    b_exp  = '{8'h22, 8'h44, 8'h5C, 8'h66, 8'h55};
    for (int i = 0; i < 5 + LAT + 1; i++) begin
      if (i < 5) begin
        a_en = 1'b1; a_addr = a_list[i];
        b_en = 1'b1; b_addr = b_list[i];
        expect_rd(1'b0, a_exp[i], $sformatf("b2b_a_%0d", i));
        expect_rd(1'b1, b_exp[i], $sformatf("b2b_b_%0d", i));
      end else begin
        idle();
      end
      step();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        got = sb[0].port ? b_dout : a_dout;
        checks++;
        if (sb[0].due != cyc || got !== sb[0].data) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h at cycle %0d due %0d", sb[0].name, got, sb[0].data, cyc, sb[0].due);
        end
        $display("back_to_back %s: %02h", sb[0].name, got);
        void'(sb.pop_front());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int busy_cnt;
    rst = 1'b1; idle();
    step(); step();
    rst = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    checks++;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b expected 1", init_busy); end
    rst = 1'b0;
    busy_cnt = 0;
    while (init_busy === 1'b1 && busy_cnt < 100) begin
      step();
      busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 16) begin errors++; $display("FAIL midclear_restart: got %0d cycles expected 16", busy_cnt); end
    $display("reset mid-clear: init_busy high for %0d cycles", busy_cnt);
    // Reset while reads are in flight.
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_din = 8'h77;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd4; b_din = 8'h88;
    step(); idle();
    a_en = 1'b1; a_addr = 4'd1;
    b_en = 1'b1; b_addr = 4'd4;
    step();
    idle(); rst = 1'b1;
    step();
    checks++;
    if (a_dout !== 8'h00) begin errors++; $display("FAIL midread_a_dout: got %02h expected 00", a_dout); end
    checks++;
    if (b_dout !== 8'h00) begin errors++; $display("FAIL midread_b_dout: got %02h expected 00", b_dout); end
    $display("reset mid-read: a_dout=%02h b_dout=%02h", a_dout, b_dout);
    rst = 1'b0;
    busy_cnt = 0;
    while (init_busy === 1'b1 && busy_cnt < 100) begin
      step();
      busy_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_latency();
    test_rd_mode();
    test_cross_port();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_sync_param.md
Name: ram_dp_sync_param

Overview:
- Parametrised true dual-port synchronous RAM. It is the successor to the team's fixed 32x4 single-write dual-read RAM.
- Two independent read/write ports (A, B) share one clock. Each port has an enable.
- Adds selectable read-during-write mode, an optional output pipeline register, and write-write collision detection.
- Adds a reset-driven memory-clear sequencer.
- Used as generic buffer storage by FIFOs, line buffers and register files.

Parameters:
- DATA_W, 8, data width in bits per word.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = no clear, memory contents undefined after reset.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- a_en  input  1  port A access enable.
- a_we  input  1  port A write enable; qualified by a_en.
- a_addr  input  ADDR_W  port A address.
- a_din  input  DATA_W  port A write data.
- a_dout  output  DATA_W  port A read data.
- b_en  input  1  port B access enable.
- b_we  input  1  port B write enable; qualified by b_en.
- b_addr  input  ADDR_W  port B address.
- b_din  input  DATA_W  port B write data.
- b_dout  output  DATA_W  port B read data.
- init_busy  output  1  high while reset or clear is in progress; port accesses are ignored.
- collision  output  1  one-cycle pulse, registered, flags a same-address double write.

Behaviour:
- Reset (rst=1 at an edge):
  - a_dout, b_dout, all pipeline stages, collision <= 0.
  - init_busy <= 1; clear counter <= 0.
  - FSM -> CLEAR if INIT_CLEAR=1, else RUN.
  - rst wins over every other input, including mid-clear and mid-access.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt], then cnt <= cnt+1.
  - After writing address DEPTH-1 -> RUN; init_busy <= 0 on that same edge.
  - Total: init_busy stays high for DEPTH cycles after rst deasserts.
  - a_en/b_en ignored; douts hold 0; collision stays 0.
- RUN state with INIT_CLEAR=0:
  - init_busy is low from the first edge after rst deasserts.
- Write:
  - Port P with P_en=1 and P_we=1 performs mem[P_addr] <= P_din at the edge.
- Read:
  - P_en=1 captures data for P_addr. It appears on P_dout after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1).
  - P_en=0: the first register stage holds. With OUT_REG=1 the output stage still advances, so in-flight data completes.
- Same-port read-during-write:
  - RD_MODE=0: P_dout shows P_din.
  - RD_MODE=1: P_dout shows the previous contents.
- Cross-port read of an address being written by the other port in the same cycle returns the old contents, in both modes.
- Write-write collision (a_en & a_we & b_en & b_we & a_addr==b_addr):
  - Port A's data is stored.
  - collision=1 for exactly one cycle after the edge.
  - Port B's own read-during-write return follows RD_MODE using b_din (write-first) or the old data (read-first). It does not reflect the stored word.
- Different-address simultaneous writes both complete, with no collision.
- Addresses wrap naturally; there is no out-of-range address (DEPTH = 2**ADDR_W).
- No combinational path from any input to any output.

Test Plan (DATA_W=8, ADDR_W=4 unless stated):
- Clear: rst 2 cycles, INIT_CLEAR=1 -> init_busy high for exactly 16 cycles after release. A port-A write of 0xAA to addr 3 during clear is ignored. Reading all 16 addresses afterwards returns 0x00.
- Latency: write 0x5C at A addr 7; next cycle read B addr 7 -> b_dout=0x5C after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1). With b_en=0 afterwards, b_dout holds 0x5C.
- RD_MODE: mem[2]=0x11; port A writes 0x22 to addr 2 with a read -> a_dout=0x22 (RD_MODE=0) or 0x11 (RD_MODE=1). A following read returns 0x22 in both modes.
- Cross-port: mem[9]=0x33; A writes 0x44 to 9 while B reads 9 in the same cycle -> b_dout=0x33. A B read next cycle gives 0x44.
- Collision: A writes 0x0F and B writes 0xF0 to addr 5 in the same cycle -> collision=1 for exactly one cycle; a later read of addr 5 returns 0x0F. Writes to addr 5 and addr 6 together -> collision stays 0, both stored.
- Reset mid-clear: assert rst at clear count 8 -> the counter restarts at 0 and init_busy stays high for a full 16 cycles after release. Reset mid-read with OUT_REG=1 -> both douts are 0 on the next cycle.
